// File: rtl/pipe_pkg.sv
// Shared pipeline constants: instruction encodings, bundle field layout and
// per-stage bundle widths for the redirect pipeline stage registers.
package pipe_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CTRL_W = 3;

  localparam logic [WORD_W-1:0] NOP_INSTR = 32'h0000_0000;

  // EX/MEM bundle layout, LSB first: IR, PC, RS2 data, RS1 data, ALU result, control.
  localparam int unsigned EXM_IR_LSB   = 0;
  localparam int unsigned EXM_PC_LSB   = EXM_IR_LSB  + WORD_W;
  localparam int unsigned EXM_RS2_LSB  = EXM_PC_LSB  + WORD_W;
  localparam int unsigned EXM_RS1_LSB  = EXM_RS2_LSB + WORD_W;
  localparam int unsigned EXM_ALU_LSB  = EXM_RS1_LSB + WORD_W;
  localparam int unsigned EXM_CTRL_LSB = EXM_ALU_LSB + WORD_W;

  localparam int unsigned IF_ID_W  = 2 * WORD_W;
  localparam int unsigned ID_EX_W  = CTRL_W + 5 * WORD_W;
  localparam int unsigned EX_MEM_W = EXM_CTRL_LSB + CTRL_W;
  localparam int unsigned MEM_WB_W = CTRL_W + 3 * WORD_W;

  // Occupancy of a stage register, encoded as {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'b00,
    OCC_MAIN    = 2'b01,
    OCC_ILLEGAL = 2'b10,
    OCC_BOTH    = 2'b11
  } occ_e;

  function automatic logic exm_is_nop(input logic [EX_MEM_W-1:0] bundle);
    return bundle[EXM_IR_LSB +: WORD_W] == NOP_INSTR;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One valid+data register of a stage: load takes new data, clear returns it
// to the bubble value; clear wins over load.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = EX_MEM_W,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_data  <= BUBBLE;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, two-entry skid
// buffer, synchronous redirect flush and a saturating stall counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = EX_MEM_W,
  parameter logic [DATA_W-1:0] BUBBLE = '0,
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              w_main_valid;
  logic [DATA_W-1:0] w_main_data;
  logic              w_skid_valid;
  logic [DATA_W-1:0] w_skid_data;

  logic              w_acc;
  logic              w_drn;
  occ_e              w_occ;

  logic              w_main_load;
  logic              w_main_clr;
  logic [DATA_W-1:0] w_main_din;
  logic              w_skid_load;
  logic              w_skid_clr;
  logic              w_skid_valid_nxt;

  logic              r_in_ready;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_acc = in_valid & r_in_ready;
  assign w_drn = w_main_valid & out_ready;
  assign w_occ = occ_e'({w_skid_valid, w_main_valid});

  // Slot control: flush beats everything; otherwise skid only fills when main
  // is stalled, and drains into main as soon as main is consumed.
  always_comb begin
    w_main_load = 1'b0;
    w_main_clr  = 1'b0;
    w_main_din  = in_data;
    w_skid_load = 1'b0;
    w_skid_clr  = 1'b0;
    if (flush) begin
      w_main_clr = 1'b1;
      w_skid_clr = 1'b1;
    end else begin
      case (w_occ)
        OCC_EMPTY: begin
          w_main_load = w_acc;
        end
        OCC_MAIN: begin
          if (w_drn) begin
            w_main_load = w_acc;
            w_main_clr  = !w_acc;
          end else begin
            w_skid_load = w_acc;
          end
        end
        OCC_BOTH: begin
          if (w_drn) begin
            w_main_load = 1'b1;
            w_main_din  = w_skid_data;
            w_skid_clr  = 1'b1;
          end
        end
        default: begin
          w_main_clr = 1'b1;
          w_skid_clr = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    w_skid_valid_nxt = w_skid_valid;
    if (w_skid_clr) begin
      w_skid_valid_nxt = 1'b0;
    end else if (w_skid_load) begin
      w_skid_valid_nxt = 1'b1;
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE)
  ) u_main (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_main_load),
    .i_clear (w_main_clr),
    .i_data  (w_main_din),
    .o_valid (w_main_valid),
    .o_data  (w_main_data)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clr),
    .i_data  (in_data),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data)
  );

  // Registered copy of !skid_valid so upstream ready never sees out_ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_in_ready <= 1'b1;
    end else begin
      r_in_ready <= !w_skid_valid_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_main_valid && !out_ready && (r_stall_cnt != CNT_MAX)) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = w_main_valid;
  assign out_data  = w_main_data;
  assign stall_cnt = r_stall_cnt;

endmodule
